// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the arbiter state/grant encodings.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    // Only meaningful when at least one client is requesting; a tie goes to
    // the client that was not served last.
    function automatic arb_grant_t pick_grant(input logic i_req,
                                              input logic d_req,
                                              input arb_grant_t last);
        if (i_req && d_req) begin
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            return GRANT_D;
        end else begin
            return GRANT_I;
        end
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// I-cache, D-cache and physical-memory signals seen by the cache arbiter.
interface cache_arbiter_if;
    import lc3b_types::*;

    logic     i_pmem_read;
    lc3b_word i_pmem_address;
    lc3b_line i_pmem_rdata;
    logic     i_pmem_resp;

    logic     d_pmem_read;
    logic     d_pmem_write;
    lc3b_word d_pmem_address;
    lc3b_line d_pmem_wdata;
    lc3b_line d_pmem_rdata;
    logic     d_pmem_resp;

    logic     mem_read;
    logic     mem_write;
    lc3b_word mem_address;
    lc3b_line mem_wdata;
    lc3b_line mem_rdata;
    logic     mem_resp;

    // Arbiter side.
    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  mem_rdata, mem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    // Caches plus memory, as driven by an environment.
    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output mem_rdata, mem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata
    );

endinterface

// File: rtl/cache_arbiter_req_reg.sv
// Request latch: captures the granted client's address, write data and
// direction on grant, and remembers who was granted last.
module arb_req_reg
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  arb_grant_t grant,
    input  lc3b_word   i_addr,
    input  lc3b_word   d_addr,
    input  lc3b_line   d_wdata,
    input  logic       d_write,
    output lc3b_word   mem_address,
    output lc3b_line   mem_wdata,
    output logic       rw,
    output arb_grant_t last_grant
);

    lc3b_word   addr_q, addr_d;
    lc3b_line   wdata_q, wdata_d;
    logic       rw_q, rw_d;
    arb_grant_t last_q, last_d;

    // A D request with read and write both high counts as a write-back.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        last_d  = last_q;
        if (load) begin
            last_d = grant;
            if (grant == GRANT_D) begin
                addr_d  = d_addr;
                wdata_d = d_wdata;
                rw_d    = d_write;
            end else begin
                addr_d  = i_addr;
                rw_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            last_q  <= GRANT_I;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            last_q  <= last_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign rw          = rw_q;
    assign last_grant  = last_q;

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a single line-wide
// physical memory port; ties alternate between clients.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ARB_IDLE    | no transaction; grant on any request, tie -> not last_grant
// ARB_SERVE_I | I-cache read outstanding at memory, wait for mem_resp
// ARB_SERVE_D | D-cache read/write outstanding at memory, wait for mem_resp
// ARB_RELEASE | one dead cycle so the served client can drop its request
module cache_arbiter
    import lc3b_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);

    arb_state_t state_q, state_d;
    logic       load;
    arb_grant_t grant_sel;
    logic       rw_q;
    arb_grant_t last_grant_q;
    logic       i_req, d_req, serving;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        grant_sel = GRANT_I;
        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    load      = 1'b1;
                    grant_sel = pick_grant(i_req, d_req, last_grant_q);
                    state_d   = (grant_sel == GRANT_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (bus.mem_resp) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    arb_req_reg u_req (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .grant       (grant_sel),
        .i_addr      (bus.i_pmem_address),
        .d_addr      (bus.d_pmem_address),
        .d_wdata     (bus.d_pmem_wdata),
        .d_write     (bus.d_pmem_write),
        .mem_address (bus.mem_address),
        .mem_wdata   (bus.mem_wdata),
        .rw          (rw_q),
        .last_grant  (last_grant_q)
    );

    // Memory strobes decode purely from flops, so reset kills them at once.
    assign serving       = (state_q == ARB_SERVE_I) || (state_q == ARB_SERVE_D);
    assign bus.mem_read  = serving & ~rw_q;
    assign bus.mem_write = serving & rw_q;

    // Completion is forwarded in the same cycle as mem_resp: no added latency.
    assign bus.i_pmem_resp  = (state_q == ARB_SERVE_I) & bus.mem_resp;
    assign bus.d_pmem_resp  = (state_q == ARB_SERVE_D) & bus.mem_resp;
    assign bus.i_pmem_rdata = bus.mem_rdata;
    assign bus.d_pmem_rdata = bus.mem_rdata;

endmodule
